// File: rtl/layer_mac_seq.sv
// Time-multiplexed fully-connected layer: N_OUT step-activated neurons over N_IN unsigned inputs,
// one shared saturating MAC and an internal signed weight register file with a readback port.
module layer_mac_seq #(
    parameter int        N_IN   = 10,
    parameter int        N_OUT  = 5,
    parameter int        DW     = 10,
    parameter int        ACC_W  = 24,
    parameter int signed THRESH = 0,
    parameter int        AW     = $clog2(N_IN * N_OUT)
) (
    input  logic                  Clock,
    input  logic                  Rst,
    input  logic                  Start,
    input  logic [N_IN*DW-1:0]    InVal,
    input  logic                  WE,
    input  logic [AW-1:0]         WAddr,
    input  logic [DW-1:0]         WData,
    input  logic [AW-1:0]         RAddr,
    output logic [DW-1:0]         RData,
    output logic                  Busy,
    output logic                  Done,
    output logic [N_OUT-1:0]      OutVal
);

    localparam int N_W = N_IN * N_OUT;
    localparam int IW  = (N_IN  > 1) ? $clog2(N_IN)  : 1;
    localparam int JW  = (N_OUT > 1) ? $clog2(N_OUT) : 1;
    localparam int PW  = 2 * DW + 1;
    localparam int SW  = ((ACC_W > PW) ? ACC_W : PW) + 1;

    localparam logic signed [SW-1:0]    SAT_MAX  = {{(SW-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}};
    localparam logic signed [SW-1:0]    SAT_MIN  = {{(SW-ACC_W+1){1'b1}}, {(ACC_W-1){1'b0}}};
    localparam logic signed [ACC_W-1:0] THRESH_V = ACC_W'(THRESH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MAC  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // Clamp a full-precision sum into the accumulator range instead of wrapping.
    function automatic logic signed [ACC_W-1:0] saturate(input logic signed [SW-1:0] v);
        logic signed [ACC_W-1:0] r;
        if (v > SAT_MAX) begin
            r = SAT_MAX[ACC_W-1:0];
        end else if (v < SAT_MIN) begin
            r = SAT_MIN[ACC_W-1:0];
        end else begin
            r = v[ACC_W-1:0];
        end
        return r;
    endfunction

    logic [1:0]              state_r;
    logic                    busy_r;
    logic                    done_r;
    logic [N_OUT-1:0]        outval_r;
    logic [N_OUT-1:0]        ov_next_r;
    logic [DW-1:0]           in_r [N_IN];
    logic signed [DW-1:0]    w_r [N_W];
    logic [DW-1:0]           rdata_r;
    logic signed [ACC_W-1:0] acc_r;
    logic [IW-1:0]           cnt_i_r;
    logic [JW-1:0]           cnt_j_r;
    logic [AW-1:0]           widx_r;

    logic signed [PW-1:0]    op_in_s;
    logic signed [PW-1:0]    op_w_s;
    logic signed [PW-1:0]    prod_s;
    logic signed [SW-1:0]    sum_s;
    logic signed [ACC_W-1:0] acc_sat_s;
    logic                    fire_s;
    logic [N_OUT-1:0]        ov_merged_s;
    logic                    last_i_s;
    logic                    last_j_s;
    logic                    wr_ok_s;
    logic                    rd_ok_s;

    // MAC datapath, activation and address qualification.
    always_comb begin
        op_in_s     = PW'($signed({1'b0, in_r[cnt_i_r]}));
        op_w_s      = PW'(w_r[widx_r]);
        prod_s      = op_in_s * op_w_s;
        sum_s       = SW'(acc_r) + SW'(prod_s);
        acc_sat_s   = saturate(sum_s);
        fire_s      = (acc_sat_s > THRESH_V);
        ov_merged_s = ov_next_r;
        ov_merged_s[cnt_j_r] = fire_s;
        last_i_s    = (cnt_i_r == IW'(N_IN - 1));
        last_j_s    = (cnt_j_r == JW'(N_OUT - 1));
        wr_ok_s     = (state_r == S_IDLE) && WE && (32'(WAddr) < 32'(N_W));
        rd_ok_s     = (32'(RAddr) < 32'(N_W));
    end

    // Sequencer: IDLE -> MAC (one product per cycle) -> DONE -> IDLE.
    always_ff @(posedge Clock) begin
        if (Rst) begin
            state_r   <= S_IDLE;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            outval_r  <= '0;
            ov_next_r <= '0;
            acc_r     <= '0;
            cnt_i_r   <= '0;
            cnt_j_r   <= '0;
            widx_r    <= '0;
            for (int k = 0; k < N_IN; k++) begin
                in_r[k] <= '0;
            end
        end else begin
            done_r <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (Start) begin
                        for (int k = 0; k < N_IN; k++) begin
                            in_r[k] <= InVal[k*DW +: DW];
                        end
                        acc_r   <= '0;
                        cnt_i_r <= '0;
                        cnt_j_r <= '0;
                        widx_r  <= '0;
                        busy_r  <= 1'b1;
                        state_r <= S_MAC;
                    end else begin
                        busy_r <= 1'b0;
                    end
                end
                S_MAC: begin
                    if (last_i_s) begin
                        acc_r     <= '0;
                        cnt_i_r   <= '0;
                        ov_next_r <= ov_merged_s;
                        if (last_j_s) begin
                            cnt_j_r  <= '0;
                            widx_r   <= '0;
                            outval_r <= ov_merged_s;
                            done_r   <= 1'b1;
                            state_r  <= S_DONE;
                        end else begin
                            cnt_j_r <= cnt_j_r + JW'(1);
                            widx_r  <= widx_r + AW'(1);
                        end
                    end else begin
                        acc_r   <= acc_sat_s;
                        cnt_i_r <= cnt_i_r + IW'(1);
                        widx_r  <= widx_r + AW'(1);
                    end
                end
                S_DONE: begin
                    busy_r  <= 1'b0;
                    state_r <= S_IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

    // Weight register file; writes only land while idle and in range.
    always_ff @(posedge Clock) begin
        if (Rst) begin
            for (int k = 0; k < N_W; k++) begin
                w_r[k] <= '0;
            end
        end else if (wr_ok_s) begin
            w_r[WAddr] <= WData;
        end else begin
            w_r[0] <= w_r[0];
        end
    end

    // Registered readback; a same-cycle write is not forwarded.
    always_ff @(posedge Clock) begin
        if (Rst) begin
            rdata_r <= '0;
        end else if (rd_ok_s) begin
            rdata_r <= w_r[RAddr];
        end else begin
            rdata_r <= '0;
        end
    end

    assign RData  = rdata_r;
    assign Busy   = busy_r;
    assign Done   = done_r;
    assign OutVal = outval_r;

endmodule

// File: tb/tb_layer_mac_seq.sv
// Directed bench for layer_mac_seq: default instance plus an ACC_W=12 instance sharing all inputs,
// checked every cycle against a transaction-level model and at key points against literals.
module tb_layer_mac_seq;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start, we;
    logic [99:0] inval;
    logic [5:0]  waddr, raddr;
    logic [9:0]  wdata;
    logic [9:0]  rdata, rdata12;
    logic        busy, busy12, done, done12;
    logic [4:0]  outval, outval12;

    int n_vec = 0;
    int n_mis = 0;
    bit chk_en = 1'b0;

    layer_mac_seq dut (
        .Clock(clk), .Rst(rst), .Start(start), .InVal(inval), .WE(we), .WAddr(waddr),
        .WData(wdata), .RAddr(raddr), .RData(rdata), .Busy(busy), .Done(done), .OutVal(outval)
    );

    layer_mac_seq #(.ACC_W(12)) dut12 (
        .Clock(clk), .Rst(rst), .Start(start), .InVal(inval), .WE(we), .WAddr(waddr),
        .WData(wdata), .RAddr(raddr), .RData(rdata12), .Busy(busy12), .Done(done12), .OutVal(outval12)
    );

    // Reference model: weights, evaluation computed at accept time, Done 51 cycles later.
    logic signed [9:0] mw [50];
    logic [9:0]        m_rdata;
    int                m_cnt;
    logic              m_busy, m_done;
    logic [4:0]        m_ov, m_ov12, m_res, m_res12;

    function automatic logic [4:0] eval(input int accw, input logic [99:0] iv,
                                        input logic wen, input logic [5:0] wa, input logic [9:0] wd);
        longint s, hi, lo;
        logic signed [9:0] wt;
        logic [4:0] r;
        hi = (64'sd1 <<< (accw - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        r = 5'd0;
        for (int j = 0; j < 5; j++) begin
            s = 0;
            for (int i = 0; i < 10; i++) begin
                wt = mw[j*10+i];
                if (wen && (int'(wa) == j*10 + i)) wt = wd;
                s = s + longint'(iv[i*10 +: 10]) * longint'(wt);
                if (s > hi) s = hi;
                if (s < lo) s = lo;
            end
            r[j] = (s > 0);
        end
        return r;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 50; k++) mw[k] <= 10'sd0;
            m_rdata <= 10'd0;
            m_cnt   <= 0;
            m_busy  <= 1'b0;
            m_done  <= 1'b0;
            m_ov    <= 5'd0;
            m_ov12  <= 5'd0;
        end else begin
            m_rdata <= (raddr < 6'd50) ? mw[raddr] : 10'd0;
            m_done  <= 1'b0;
            if (m_cnt == 0 && we && waddr < 6'd50) mw[waddr] <= wdata;
            if (m_cnt == 0) begin
                if (start) begin
                    m_res   <= eval(24, inval, we, waddr, wdata);
                    m_res12 <= eval(12, inval, we, waddr, wdata);
                    m_cnt   <= 1;
                    m_busy  <= 1'b1;
                end
            end else if (m_cnt == 51) begin
                m_cnt  <= 0;
                m_busy <= 1'b0;
            end else begin
                m_cnt <= m_cnt + 1;
                if (m_cnt == 50) begin
                    m_done <= 1'b1;
                    m_ov   <= m_res;
                    m_ov12 <= m_res12;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Cycle-by-cycle comparison against the model, away from the rising edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy",     32'(busy),     32'(m_busy));
            chk("done",     32'(done),     32'(m_done));
            chk("outval",   32'(outval),   32'(m_ov));
            chk("rdata",    32'(rdata),    32'(m_rdata));
            chk("busy12",   32'(busy12),   32'(m_busy));
            chk("done12",   32'(done12),   32'(m_done));
            chk("outval12", 32'(outval12), 32'(m_ov12));
            chk("rdata12",  32'(rdata12),  32'(m_rdata));
        end
    end

    task automatic cyc(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input int a, input int d);
        waddr = 6'(a);
        wdata = 10'(d);
        we    = 1'b1;
        cyc();
        we    = 1'b0;
    endtask

    task automatic set_all_in(input int v);
        for (int i = 0; i < 10; i++) inval[i*10 +: 10] = 10'(v);
    endtask

    task automatic run_eval(output int lat);
        start = 1'b1;
        cyc();
        start = 1'b0;
        lat = 1;
        while (!done && lat < 200) begin
            cyc();
            lat++;
        end
        if (!done) begin
            n_vec++;
            n_mis++;
            $display("FAIL done_timeout: no Done within %0d cycles", lat);
        end
    endtask

    task automatic sweep_zero(input string name);
        for (int a = 0; a < 50; a++) begin
            raddr = 6'(a);
            cyc();
            chk(name, 32'(rdata), 32'd0);
        end
    endtask

    int lat;
    int dones;

    initial begin
        rst = 1'b1; start = 1'b0; we = 1'b0; inval = '0;
        waddr = 6'd0; wdata = 10'd0; raddr = 6'd0;
        cyc();
        chk_en = 1'b1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_outval", 32'(outval), 32'd0);
        cyc();
        rst = 1'b0;
        sweep_zero("rst_rdata");
        raddr = 6'd55;
        cyc();
        chk("rdata_oor", 32'(rdata), 32'd0);

        // Write -5 to entry 3 while reading it: old value first, new one next cycle.
        waddr = 6'd3; wdata = 10'h3FB; raddr = 6'd3; we = 1'b1;
        cyc();
        chk("rd_same_cycle_old", 32'(rdata), 32'd0);
        we = 1'b0;
        cyc();
        chk("rd_after_wr", 32'(rdata), 32'h3FB);
        wr(50, 7);
        for (int a = 0; a < 50; a++) begin
            raddr = 6'(a);
            cyc();
            chk("rd_sweep", 32'(rdata), (a == 3) ? 32'h3FB : 32'd0);
        end

        // +1 / -1 / 0 neuron weights, inputs all 2.
        for (int a = 0; a < 50; a++) wr(a, (a < 10) ? 1 : ((a < 20) ? -1 : 0));
        set_all_in(2);
        run_eval(lat);
        chk("latency", 32'(lat), 32'd51);
        chk("ov_basic", 32'(outval), 32'h01);
        chk("ov12_basic", 32'(outval12), 32'h01);
        chk("model_basic", 32'(m_ov), 32'h01);
        cyc();
        chk("busy_after", 32'(busy), 32'd0);
        set_all_in(0);
        run_eval(lat);
        chk("latency_b2b", 32'(lat), 32'd51);
        chk("ov_zero_in", 32'(outval), 32'h00);
        cyc();

        // Saturation: large positive, large negative, and clamp that flips the sign.
        for (int a = 0; a < 50; a++) wr(a, 511);
        set_all_in(1023);
        run_eval(lat);
        chk("ov12_satpos", 32'(outval12), 32'h1F);
        chk("ov_pos", 32'(outval), 32'h1F);
        cyc();
        for (int a = 0; a < 50; a++) wr(a, -512);
        run_eval(lat);
        chk("ov12_satneg", 32'(outval12), 32'h00);
        cyc();
        for (int a = 0; a < 9; a++) wr(a, 511);
        inval[90 +: 10] = 10'd5;
        run_eval(lat);
        chk("ov_noclamp", 32'(outval), 32'h01);
        chk("ov12_clamp", 32'(outval12), 32'h00);
        cyc();

        // Start and WE while busy must be ignored.
        start = 1'b1;
        cyc();
        start = 1'b0;
        dones = 0;
        for (int c = 1; c <= 120; c++) begin
            start = (c == 5 || c == 20);
            we    = (c == 5 || c == 20);
            waddr = 6'd0;
            wdata = 10'd123;
            cyc();
            if (done) dones++;
        end
        start = 1'b0;
        we = 1'b0;
        chk("single_done", 32'(dones), 32'd1);
        raddr = 6'd0;
        cyc();
        chk("w0_kept", 32'(rdata), 32'h1FF);

        // Abort mid-evaluation with reset.
        start = 1'b1;
        cyc();
        start = 1'b0;
        cyc(19);
        rst = 1'b1;
        cyc();
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_outval", 32'(outval), 32'd0);
        rst = 1'b0;
        dones = 0;
        for (int c = 0; c < 60; c++) begin
            cyc();
            if (done) dones++;
        end
        chk("abort_no_done", 32'(dones), 32'd0);
        sweep_zero("abort_rdata");
        for (int a = 20; a < 30; a++) wr(a, 3);
        set_all_in(1);
        run_eval(lat);
        chk("fresh_latency", 32'(lat), 32'd51);
        chk("fresh_ov", 32'(outval), 32'h04);
        chk("fresh_ov12", 32'(outval12), 32'h04);
        cyc(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
